mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit for the pipelined CPU core. It owns the HI/LO architectural registers. It executes MULT, MULTU, DIV, DIVU, MADD, MADDU, MTHI and MTLO through a start/busy/done handshake, and computes multiplies with a shift-add engine and divides with a restoring divider. Decode issues operations to it, and the hazard unit stalls on busy.

Parameters:
WIDTH, 32, operand width and HI/LO register width in bits; legal values are even and at least 4.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  operation request; accepted only when busy=0
op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MTHI, 111 MTLO
src_a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
src_b  input  WIDTH  rt operand: multiplier or divisor
flush  input  1  abort any in-flight operation
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO have been written
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
div_by_zero  output  1  sticky flag, set by a DIV/DIVU with src_b=0, cleared at the next accepted start

Behaviour:
- Reset (rst_n=0 at an edge) has priority over all other inputs, including mid-operation. It forces state=IDLE, and busy, done, hi, lo, div_by_zero, the counter and all datapath registers to 0.
- State machine states: IDLE, MUL, DIV, FIX.
- IDLE, start=1, flush=0:
  - Latch op, src_a and src_b.
  - Clear div_by_zero.
  - MTHI/MTLO: write hi (or lo) at this same edge, and pulse done=1 in the next cycle. busy stays 0.
  - MULT, MULTU, MADD, MADDU: go to MUL with counter=WIDTH.
  - DIV, DIVU: go to DIV with counter=WIDTH.
- Signed ops (MULT, MADD, DIV) load absolute values of the operands and record the result signs. Unsigned ops load the operands unchanged.
- MUL: one shift-add step per cycle over a 2*WIDTH accumulator, counter decrements each cycle. Go to FIX when counter reaches 1 at an edge.
- DIV: one restoring step per cycle, per edge:
  - Trial value = remainder minus (divisor shifted).
  - If the trial is negative, shift a 0 into the quotient.
  - Otherwise update the remainder and shift a 1 into the quotient.
  - Decrement the counter; go to FIX after WIDTH steps.
- FIX is one cycle. It applies the sign fix-up and writes HI/LO:
  - MULT/MULTU: {hi,lo} = product.
  - MADD/MADDU: {hi,lo} = {hi,lo} + product, modulo 2^(2*WIDTH).
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Quotient sign is sign(a) XOR sign(b). Remainder sign follows the dividend.
  - Returns to IDLE.
- Timing: start accepted at edge E, busy=1 from E+1 through the cycle before edge E+WIDTH+2. HI/LO written at edge E+WIDTH+2, then busy=0 and done=1 for exactly one cycle.
- Latency is WIDTH+2 cycles from accept to result visible.
- A start during the done cycle is accepted (back-to-back issue allowed).
- start while busy=1 is ignored. There is no queueing, so the requester must hold start until busy=0.
- Divide by zero:
  - Sets div_by_zero=1 at the FIX write.
  - Result is lo = all ones and hi = src_a, for both signed and unsigned.
  - Still takes full latency.
- Signed overflow (DIV of most-negative value by -1): lo = most-negative value, hi = 0. No flag.
- flush=1 while busy=1: return to IDLE at the next edge with no done pulse. hi, lo and div_by_zero are left unchanged.
- flush=1 in IDLE together with start=1: start is dropped. flush always has priority over start.
- hi and lo change only at FIX, at an MTHI/MTLO accept, or at reset.

Test Plan:
- Reset, then MULT with src_a=0xFFFFFFFD, src_b=7 -> at start+34 cycles: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- DIVU 100/7 -> lo=14, hi=2. Then DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, issued back-to-back in the done cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. Then DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 until the next start.
- MTHI 1, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=2, lo=0. Then MADD 0xFFFFFFFF*1 -> hi=1, lo=0xFFFFFFFF.
- Flush mid-operation:
  - DIVU 100/7 with flush asserted at cycle 10 -> busy=0 next cycle, no done pulse, hi/lo keep prior values.
  - Reset asserted mid-MULT -> all outputs 0.
- WIDTH=8, CNT_W=4 build:
  - MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 10 cycles.
  - DIV 0x80/0x03 -> lo=0xD6, hi=0xFE.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit owning the HI/LO registers.
// Multiplies use a shift-add engine and divides use a restoring divider.
// Both engines share one 2*WIDTH accumulator and take WIDTH iteration steps,
// followed by one FIX cycle that applies signs and writes HI/LO.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  // Two's-complement magnitude; the most-negative value maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    abs_val = v[WIDTH-1] ? (-v) : v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   mag_q, mag_d;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic               neg_q, neg_d;      // product / quotient negative
  logic               rneg_q, rneg_d;    // remainder negative (follows dividend)
  logic               bzero_q, bzero_d;  // divisor was zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] madd_sum;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand preparation and single-step datapath for both engines.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    opa       = signed_op ? abs_val(src_a) : src_a;
    opb       = signed_op ? abs_val(src_b) : src_b;

    // Shift-add: add multiplicand to upper half when the current multiplier bit is set.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: bring next dividend bit into the partial remainder and trial-subtract.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    div_ge    = (div_shift >= {1'b0, mag_q});
    if (div_ge) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // Sign fix-up applied in the FIX cycle.
    prod_fix = neg_q ? (-acc_q) : acc_q;
    madd_sum = {hi_q, lo_q} + prod_fix;
    quo_fix  = neg_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and next-value logic of the control FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          a_d     = src_a;
          dz_d    = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          bzero_d = (src_b == {WIDTH{1'b0}});
          neg_d   = signed_op ? (src_a[WIDTH-1] ^ src_b[WIDTH-1]) : 1'b0;
          rneg_d  = signed_op ? src_a[WIDTH-1] : 1'b0;
          case (op)
            OP_MTHI: begin
              hi_d   = src_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = src_a;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              mag_d   = opb;
              acc_d   = {{WIDTH{1'b0}}, opa};
            end
            default: begin
              state_d = S_MUL;
              mag_d   = opa;
              acc_d   = {{WIDTH{1'b0}}, opb};
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU: begin
              {hi_d, lo_d} = prod_fix;
            end
            OP_MADD, OP_MADDU: begin
              {hi_d, lo_d} = madd_sum;
            end
            OP_DIV, OP_DIVU: begin
              if (bzero_q) begin
                lo_d = {WIDTH{1'b1}};
                hi_d = a_q;
                dz_d = 1'b1;
              end else begin
                lo_d = quo_fix;
                hi_d = rem_fix;
              end
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'b000;
      a_q     <= {WIDTH{1'b0}};
      mag_q   <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: a 32-bit instance for the main
// scenarios and an 8-bit instance for the narrow build.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dz)
  );

  mul_div_unit #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dz8)
  );

  // Issue one op on the 32-bit unit and wait for done; lat counts cycles after the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bc);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; lat = 1; bc = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; lat = 1;
    while (done8 !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; src_a = 32'h0; src_b = 32'h0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'b000; a8 = 8'h00; b8 = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'h0) begin
      errors++; $display("FAIL reset32 got %h want 0", {busy, done, dz, hi, lo});
    end
    checks++;
    if ({busy8, done8, dz8, hi8, lo8} !== 19'h0) begin
      errors++; $display("FAIL reset8 got %h want 0", {busy8, done8, dz8, hi8, lo8});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int lat, bc;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bc);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", lat); end
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %b want 0", busy); end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      errors++; $display("FAIL mult_result got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_div_back_to_back();
    int lat, bc;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc);
    checks++;
    if ({hi, lo, lat} !== {32'd2, 32'd14, 32'd34}) begin
      errors++; $display("FAIL divu got hi=%h lo=%h lat=%0d want hi=2 lo=e lat=34", hi, lo, lat);
    end
    // issued in the done cycle of the previous op
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
    checks++;
    if ({hi, lo, lat} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 32'd34}) begin
      errors++; $display("FAIL div_b2b got hi=%h lo=%h lat=%0d want hi=ffffffff lo=fffffffd lat=34", hi, lo, lat);
    end
  endtask

  task automatic test_div_special();
    int lat, bc;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++;
    if ({hi, lo, dz} !== {32'h0, 32'h80000000, 1'b0}) begin
      errors++; $display("FAIL div_overflow got hi=%h lo=%h dz=%b want hi=0 lo=80000000 dz=0", hi, lo, dz);
    end
    run_op(OP_DIVU, 32'd5, 32'd0, lat, bc);
    checks++;
    if ({hi, lo, dz, lat} !== {32'd5, 32'hFFFFFFFF, 1'b1, 32'd34}) begin
      errors++; $display("FAIL divu_zero got hi=%h lo=%h dz=%b lat=%0d want hi=5 lo=ffffffff dz=1 lat=34", hi, lo, dz, lat);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dz !== 1'b1) begin errors++; $display("FAIL dz_sticky got %b want 1", dz); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, lat, bc);
    checks++;
    if ({hi, lo, dz} !== {32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1}) begin
      errors++; $display("FAIL div_zero_signed got hi=%h lo=%h dz=%b want hi=fffffff9 lo=ffffffff dz=1", hi, lo, dz);
    end
    // dz must clear at the next accepted start (here during the multiply)
    start = 1'b1; op = OP_MULTU; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (dz !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", dz); end
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic test_madd();
    int lat, bc;
    run_op(OP_MTHI, 32'd1, 32'd0, lat, bc);
    checks++;
    if ({lat, busy, hi} !== {32'd1, 1'b0, 32'd1}) begin
      errors++; $display("FAIL mthi got lat=%0d busy=%b hi=%h want lat=1 busy=0 hi=1", lat, busy, hi);
    end
    run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, lat, bc);
    checks++;
    if ({lat, lo} !== {32'd1, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL mtlo got lat=%0d lo=%h want lat=1 lo=ffffffff", lat, lo);
    end
    run_op(OP_MADDU, 32'd1, 32'd1, lat, bc);
    checks++;
    if ({hi, lo, lat} !== {32'd2, 32'd0, 32'd34}) begin
      errors++; $display("FAIL maddu got hi=%h lo=%h lat=%0d want hi=2 lo=0 lat=34", hi, lo, lat);
    end
    run_op(OP_MADD, 32'hFFFFFFFF, 32'd1, lat, bc);
    checks++;
    if ({hi, lo} !== {32'd1, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL madd got hi=%h lo=%h want hi=1 lo=ffffffff", hi, lo);
    end
  endtask

  task automatic test_flush();
    int pulses;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);  // now in cycle 10 after accept
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL flush_idle got busy=%b done=%b want 0 0", busy, done);
    end
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) pulses++; end
    checks++;
    if ({pulses, hi, lo} !== {32'd0, 32'd1, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL flush_keep got pulses=%0d hi=%h lo=%h want 0 1 ffffffff", pulses, hi, lo);
    end
    // flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'h1234;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if ({done, busy, hi} !== {1'b0, 1'b0, 32'd1}) begin
      errors++; $display("FAIL flush_start got done=%b busy=%b hi=%h want 0 0 1", done, busy, hi);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    checks++;
    if ({hi, lo, lat} !== {32'd0, 32'd6, 32'd34}) begin
      errors++; $display("FAIL busy_ignore got hi=%h lo=%h lat=%0d want hi=0 lo=6 lat=34", hi, lo, lat);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'h0) begin
      errors++; $display("FAIL reset_mid got %h want 0", {busy, done, dz, hi, lo});
    end
    pulses = 0;
    repeat (35) begin @(negedge clk); if (done === 1'b1) pulses++; end
    checks++;
    if ({pulses, lo} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL reset_mid_quiet got pulses=%0d lo=%h want 0 0", pulses, lo);
    end
  endtask

  task automatic test_width8();
    int lat;
    run_op8(OP_MULTU, 8'hFF, 8'hFF, lat);
    checks++;
    if ({hi8, lo8, lat} !== {8'hFE, 8'h01, 32'd10}) begin
      errors++; $display("FAIL w8_multu got hi=%h lo=%h lat=%0d want hi=fe lo=01 lat=10", hi8, lo8, lat);
    end
    run_op8(OP_DIV, 8'h80, 8'h03, lat);
    checks++;
    if ({hi8, lo8, lat} !== {8'hFE, 8'hD6, 32'd10}) begin
      errors++; $display("FAIL w8_div got hi=%h lo=%h lat=%0d want hi=fe lo=d6 lat=10", hi8, lo8, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_back_to_back();
    test_div_special();
    test_madd();
    test_flush();
    test_busy_ignore();
    test_reset_mid();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
